// File: rtl/cxl_credit_pkg.sv
// Shared types and channel indices for the CXL credit counter bank.
// Holds the return FSM states and the default message-class channel numbers.
package cxl_credit_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } ret_state_e;

   localparam int CH_REQ     = 0;
   localparam int CH_RSP     = 1;
   localparam int CH_DATA    = 2;
   localparam int DEF_NUM_CH = 3;

   typedef logic [$clog2(DEF_NUM_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/credit_sat_ctr.sv
// One credit channel: signed sum of inc/dec/return, clamp to [0, 2^CNT_W-1],
// clear priority, sticky overflow/underflow flags and a registered low flag.
module credit_sat_ctr #(
   parameter int CNT_W    = 8,
   parameter int INIT_VAL = 0,
   parameter int LOW_WM   = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc_en,
   input  logic [CNT_W-1:0] i_inc_val,
   input  logic             i_dec_en,
   input  logic [CNT_W-1:0] i_dec_val,
   input  logic             i_ret_en,
   input  logic [CNT_W-1:0] i_ret_val,
   input  logic             i_clr,
   input  logic             i_err_clr,
   output logic [CNT_W-1:0] o_count,
   output logic             o_low,
   output logic             o_ovf,
   output logic             o_udf
);

   localparam int SW = CNT_W + 2;
   localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_VAL);
   localparam logic [CNT_W:0]   LOW_C  = (CNT_W+1)'(LOW_WM);

   logic [CNT_W-1:0]        r_count;
   logic                    r_low;
   logic                    r_ovf;
   logic                    r_udf;
   logic signed [SW-1:0]    w_inc;
   logic signed [SW-1:0]    w_dec;
   logic signed [SW-1:0]    w_ret;
   logic signed [SW-1:0]    w_sum;
   logic                    w_ovf;
   logic                    w_udf;
   logic [CNT_W-1:0]        w_next;

   always_comb begin
      w_inc  = i_inc_en ? $signed({2'b00, i_inc_val}) : '0;
      w_dec  = i_dec_en ? $signed({2'b00, i_dec_val}) : '0;
      w_ret  = i_ret_en ? $signed({2'b00, i_ret_val}) : '0;
      w_sum  = $signed({2'b00, r_count}) + w_inc - w_dec - w_ret;
      // Two spare bits: the MSB is the sign, bit CNT_W marks a sum past all-ones.
      w_udf  = w_sum[SW-1];
      w_ovf  = !w_sum[SW-1] && w_sum[CNT_W];
      w_next = w_sum[CNT_W-1:0];
      if (i_clr) begin
         w_next = INIT_C;
      end else if (w_udf) begin
         w_next = '0;
      end else if (w_ovf) begin
         w_next = '1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= INIT_C;
         r_low   <= ({1'b0, INIT_C} < LOW_C);
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         r_count <= w_next;
         r_low   <= ({1'b0, w_next} < LOW_C);
         r_ovf   <= (r_ovf && !i_err_clr) || (!i_clr && w_ovf);
         r_udf   <= (r_udf && !i_err_clr) || (!i_clr && w_udf);
      end
   end

   assign o_count = r_count;
   assign o_low   = r_low;
   assign o_ovf   = r_ovf;
   assign o_udf   = r_udf;

endmodule

// File: rtl/cxl_credit_counter_bank.sv
// Multi-channel saturating credit counter bank with optional round-robin
// credit-return engine, built only when CXL_CREDIT_RET_EN is defined.
module cxl_credit_counter_bank
   import cxl_credit_pkg::*;
#(
   parameter int NUM_CH     = 3,
   parameter int CNT_W      = 8,
   parameter int INIT_VAL   = 0,
   parameter int LOW_WM     = 4,
   parameter int RET_THRESH = 16
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [NUM_CH-1:0]              i_inc_en,
   input  logic [NUM_CH-1:0][CNT_W-1:0]   i_inc_val,
   input  logic [NUM_CH-1:0]              i_dec_en,
   input  logic [NUM_CH-1:0][CNT_W-1:0]   i_dec_val,
   input  logic [NUM_CH-1:0]              i_clr,
   input  logic                           i_err_clr,
   input  logic                           i_ret_ready,
   output logic [NUM_CH-1:0][CNT_W-1:0]   o_count_val,
   output logic [NUM_CH-1:0]              o_low,
   output logic [NUM_CH-1:0]              o_ovf,
   output logic [NUM_CH-1:0]              o_udf,
   output logic                           o_ret_valid,
   output logic [$clog2(NUM_CH)-1:0]      o_ret_ch,
   output logic [CNT_W-1:0]               o_ret_val
);

   localparam int CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0] w_ret_en;
   logic [CNT_W-1:0]  w_ret_val;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      credit_sat_ctr #(
         .CNT_W    (CNT_W),
         .INIT_VAL (INIT_VAL),
         .LOW_WM   (LOW_WM)
      ) u_ctr (
         .i_clk     (i_clk),
         .i_rst_n   (i_rst_n),
         .i_inc_en  (i_inc_en[g]),
         .i_inc_val (i_inc_val[g]),
         .i_dec_en  (i_dec_en[g]),
         .i_dec_val (i_dec_val[g]),
         .i_ret_en  (w_ret_en[g]),
         .i_ret_val (w_ret_val),
         .i_clr     (i_clr[g]),
         .i_err_clr (i_err_clr),
         .o_count   (o_count_val[g]),
         .o_low     (o_low[g]),
         .o_ovf     (o_ovf[g]),
         .o_udf     (o_udf[g])
      );
   end

`ifdef CXL_CREDIT_RET_EN
   localparam logic [CNT_W:0] THR_C = (CNT_W+1)'(RET_THRESH);

   ret_state_e        r_state;
   ret_state_e        w_state_nxt;
   logic [CH_W-1:0]   r_ptr;
   logic [CH_W-1:0]   r_ret_ch;
   logic [CNT_W-1:0]  r_ret_val;
   logic [CH_W-1:0]   w_pick;
   logic [NUM_CH-1:0] w_elig;
   logic              w_found;
   logic              w_load;
   logic              w_fire;

   // Round-robin search: first eligible channel at or after the pointer.
   always_comb begin
      w_elig  = '0;
      w_found = 1'b0;
      w_pick  = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         w_elig[ch] = ({1'b0, o_count_val[ch]} >= THR_C) && !i_clr[ch];
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (!w_found && w_elig[(int'(r_ptr) + i) % NUM_CH]) begin
            w_found = 1'b1;
            w_pick  = CH_W'((int'(r_ptr) + i) % NUM_CH);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_fire      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_load      = 1'b1;
               w_state_nxt = OFFER;
            end
         end
         OFFER: begin
            if (i_ret_ready) begin
               w_fire      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_ret_ch  <= '0;
         r_ret_val <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_ret_ch  <= w_pick;
            r_ret_val <= o_count_val[w_pick];
         end
         if (w_fire) begin
            r_ptr <= (r_ret_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ret_ch + 1'b1;
         end
      end
   end

   always_comb begin
      w_ret_en = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         w_ret_en[ch] = w_fire && (r_ret_ch == CH_W'(ch));
      end
   end

   assign w_ret_val   = r_ret_val;
   assign o_ret_valid = (r_state == OFFER);
   assign o_ret_ch    = r_ret_ch;
   assign o_ret_val   = r_ret_val;
`else
   logic w_unused_ret;

   assign w_unused_ret = i_ret_ready ^ (RET_THRESH == 0) ^ (CH_W == 0);
   assign w_ret_en     = '0;
   assign w_ret_val    = '0;
   assign o_ret_valid  = 1'b0;
   assign o_ret_ch     = '0;
   assign o_ret_val    = '0;
`endif

endmodule

// File: doc/cxl_credit_counter_bank.md
# cxl_credit_counter_bank

Multi-channel saturating credit counter bank for the CXL link layer. It holds one up/down credit counter per message class (REQ/RSP/DATA by default), tracks overflow and underflow per channel, and flags low credit. An optional credit-return engine offers accumulated credits back to the link layer over a valid/ready handshake. It sits between the flit pack/unpack logic (which drives increments and decrements) and the link-layer control flit generator (which consumes returns).

## Interface
- NUM_CH, 3, number of independent credit channels
- CNT_W, 8, counter width in bits
- INIT_VAL, 0, per-channel count after reset and after i_clr
- LOW_WM, 4, o_low asserts while count < LOW_WM
- RET_THRESH, 16, minimum count for a channel to be offered for return
---
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_inc_en  in  NUM_CH  per-channel increment enable
- i_inc_val  in  NUM_CH x CNT_W  per-channel increment amount
- i_dec_en  in  NUM_CH  per-channel decrement enable
- i_dec_val  in  NUM_CH x CNT_W  per-channel decrement amount
- i_clr  in  NUM_CH  synchronous clear of the channel count to INIT_VAL
- i_err_clr  in  1  clears all sticky error flags
- i_ret_ready  in  1  return consumer accepts the offer
- o_count_val  out  NUM_CH x CNT_W  registered channel counts
- o_low  out  NUM_CH  registered low-watermark flags
- o_ovf  out  NUM_CH  sticky overflow flags
- o_udf  out  NUM_CH  sticky underflow flags
- o_ret_valid  out  1  return offer valid
- o_ret_ch  out  clog2(NUM_CH)  channel being returned
- o_ret_val  out  CNT_W  credit amount being returned

## Operation
- Per channel, every cycle: sum = count + (inc_en ? inc_val : 0) − (dec_en ? dec_val : 0) − (ret_fire && o_ret_ch==ch ? o_ret_val : 0). The sum is computed signed in CNT_W+2 bits with no intermediate saturation.
- Clamping: sum > 2^CNT_W−1 gives count = all ones and sets o_ovf. Sum < 0 gives count = 0 and sets o_udf. Otherwise count = sum.
- i_clr has priority over all arithmetic in that channel. It loads INIT_VAL and sets no flags.
- Sticky flags hold until i_err_clr. If a new error coincides with i_err_clr, the flag stays set.
- o_low = (next count < LOW_WM), registered together with the count.
- Return FSM, states IDLE and OFFER:
  - IDLE: a channel is eligible when count ≥ RET_THRESH and i_clr is low. A round-robin pointer picks the first eligible channel at or after the pointer. On a pick, the FSM latches o_ret_ch and o_ret_val = the current count, and moves to OFFER.
  - OFFER: o_ret_valid=1, and o_ret_ch and o_ret_val stay stable until i_ret_ready. ret_fire = o_ret_valid && i_ret_ready. On fire, the latched amount is subtracted (per the formula above), the pointer moves to o_ret_ch+1 mod NUM_CH, and the FSM returns to IDLE.
  - i_clr on the offered channel while in OFFER does not withdraw the offer. The fire still happens, and clr takes priority for the count.

## Timing
- Reset values: o_count_val=INIT_VAL, o_ovf=o_udf=0, o_low=(INIT_VAL<LOW_WM), o_ret_valid=0, o_ret_ch=0, o_ret_val=0, FSM=IDLE, pointer=0.
- Count and flag update latency is one cycle: inputs at edge N appear on the outputs after edge N.
- Return offer: eligibility sampled at edge N gives o_ret_valid high after edge N.
- After a fire at edge M, IDLE evaluates at edge M+1, so the next offer can appear no earlier than after M+1 (one bubble).
- Asserting reset mid-offer drops o_ret_valid immediately. The offer is lost, and no credits are subtracted.

## Configuration
- CXL_CREDIT_RET_EN:
  - Defined: the return FSM and round-robin pointer are built as described above.
  - Undefined: o_ret_valid, o_ret_ch and o_ret_val are tied to 0, i_ret_ready is ignored, and the return term in the sum is zero. All counting and flag behaviour is unchanged.

## Structure
- Package cxl_credit_pkg holds:
  - the ret_state_e enum {IDLE, OFFER}
  - default channel indices CH_REQ=0, CH_RSP=1, CH_DATA=2
  - the ch_idx_t typedef
- Sub-module credit_sat_ctr holds one channel's datapath: the signed sum, clamp, clr priority, sticky flags and low flag. It is instantiated NUM_CH times. The FSM and arbiter live in the top.

## Test plan
- Reset → all counts 0, o_low all 1, o_ret_valid 0, all flags 0.
- ch0 = 250, inc 10 → ch0 = 255 and o_ovf[0]=1. Then i_err_clr → o_ovf[0]=0, and the count stays 255.
- ch1 = 5, inc 3 and dec 10 in the same cycle → ch1 = 0 and o_udf[1]=1. Separately, ch2 = 100, inc 20 and dec 7 → 113 with no flags.
- Return with ch0=20 and ch2=30 (macro defined):
  - First offer is ch0, val 20. Hold i_ret_ready low for 3 cycles: the offer stays stable.
  - Raise ready → ch0 = 0 after the edge, then a one-cycle bubble, then an offer of ch2, val 30.
- Offer on ch1 with inc 5 on the fire cycle → ch1 = 5 after the edge. Then i_clr on an offered channel → count = INIT_VAL, fire completes, and no o_udf.
- Reset asserted while in OFFER → o_ret_valid drops asynchronously, and counts return to INIT_VAL.
